// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor, LSB first, one bit per clock.
// A single full-adder cell plus a carry flop does all arithmetic; operands are
// loaded into shift registers on an accepted start and the sum bits are shifted
// into the result register from the MSB end.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only while busy=0
//   sub        0: a+b, 1: a-b (sampled with start)
//   a, b       WIDTH-bit operands (sampled with start)
//   busy       high while bits are being processed (WIDTH cycles)
//   done       one-cycle pulse; result/flags valid from this cycle
//   result     WIDTH-bit sum/difference, modulo 2^WIDTH
//   carry_out  final carry; in sub mode 1 = no borrow
//   overflow   signed overflow (carry into MSB xor carry out of MSB)
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_a_q, sreg_a_d;
  logic [WIDTH-1:0] sreg_b_q, sreg_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;

  // Full-adder cell on the current bit slice.
  logic fa_sum, fa_cout;
  always_comb begin
    fa_sum  = sreg_a_q[0] ^ sreg_b_q[0] ^ carry_q;
    fa_cout = (sreg_a_q[0] & sreg_b_q[0]) |
              (sreg_a_q[0] & carry_q) |
              (sreg_b_q[0] & carry_q);
  end

  always_comb begin
    state_d     = state_q;
    sreg_a_d    = sreg_a_q;
    sreg_b_d    = sreg_b_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
          sreg_a_d = a;
          sreg_b_d = sub ? ~b : b;
          carry_d  = sub;
          cnt_d    = '0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        result_d = {fa_sum, result_q[WIDTH-1:1]};
        sreg_a_d = {1'b0, sreg_a_q[WIDTH-1:1]};
        sreg_b_d = {1'b0, sreg_b_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // carry_q here is the carry into the MSB.
          carry_out_d = fa_cout;
          overflow_d  = carry_q ^ fa_cout;
          state_d     = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sreg_a_q    <= '0;
      sreg_b_q    <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_a_q    <= sreg_a_d;
      sreg_b_q    <= sreg_b_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy      = (state_q == S_SHIFT);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub (WIDTH=8) with hand-computed expectations.
module tb_serial_add_sub;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int n_checks;
  int n_fail;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called #1 after a clock edge; returns #1 after the accepting edge.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
    a     = ta;
    b     = tb;
    sub   = ts;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for done, counting busy cycles and latency from the accepting edge.
  // inject > 0 pulses start with other operands on that busy cycle.
  task automatic wait_done(input string tag, input logic [W-1:0] er, input logic eco,
                           input logic eov, input int inject);
    int busy_cnt;
    int lat;
    busy_cnt = busy ? 1 : 0;
    lat      = 0;
    for (int i = 1; i <= 20; i++) begin
      if (inject > 0 && i == inject + 1) begin
        a     = 8'd1;
        b     = 8'd1;
        sub   = 1'b1;
        start = 1'b1;
      end
      @(posedge clk);
      #1 start = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) busy_cnt++;
    end
    check({tag, "_latency"}, lat, W);
    check({tag, "_busy_cycles"}, busy_cnt, W);
    check({tag, "_result"}, result, er);
    check({tag, "_carry"}, carry_out, eco);
    check({tag, "_ovf"}, overflow, eov);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic ts, input logic [W-1:0] er, input logic eco, input logic eov);
    start_op(ta, tb, ts);
    wait_done(tag, er, eco, eov, 0);
  endtask

  initial begin
    int seen_done;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    sub      = 1'b0;
    a        = '0;
    b        = '0;
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", {busy, done, carry_out, overflow, result}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: basic add, latency and one-cycle done
    run_op("add_100_27", 8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0);
    @(posedge clk);
    #1 check("done_pulse_width", {busy, done}, 0);
    check("result_held", result, 127);

    // 2: unsigned carry and signed overflow
    run_op("add_200_100", 8'd200, 8'd100, 1'b0, 8'd44, 1'b1, 1'b0);
    run_op("add_127_1", 8'd127, 8'd1, 1'b0, 8'd128, 1'b0, 1'b1);

    // 3: subtraction
    run_op("sub_5_3", 8'd5, 8'd3, 1'b1, 8'd2, 1'b1, 1'b0);
    run_op("sub_3_5", 8'd3, 8'd5, 1'b1, 8'd254, 1'b0, 1'b0);
    run_op("sub_128_1", 8'd128, 8'd1, 1'b1, 8'd127, 1'b1, 1'b1);
    run_op("sub_7_0", 8'd7, 8'd0, 1'b1, 8'd7, 1'b1, 1'b0);

    // 4: start during busy is ignored
    start_op(8'd50, 8'd60, 1'b0);
    wait_done("ignore_start", 8'd110, 1'b0, 1'b0, 2);
    @(posedge clk);
    #1 check("ignore_single_done", {busy, done}, 0);

    // 5: back-to-back accept in the DONE cycle
    run_op("b2b_first", 8'd10, 8'd20, 1'b0, 8'd30, 1'b0, 1'b0);
    run_op("b2b_second", 8'd20, 8'd30, 1'b1, 8'd246, 1'b0, 1'b0);

    // 6: reset mid-operation
    @(posedge clk);
    #1 start_op(8'd1, 8'd2, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("abort_outputs", {busy, done, carry_out, overflow, result}, 0);
    @(negedge clk) rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 if (done || busy) seen_done++;
    end
    check("abort_no_done", seen_done, 0);
    run_op("after_reset", 8'd255, 8'd1, 1'b0, 8'd0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
